fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 24: sample width in bits; SHALL be a multiple of 8.
REQ-002 Parameter NUM_BYTES, default 2: bytes written per frame, taken MSB-first; SHALL satisfy 1 <= NUM_BYTES <= DATA_SIZE/8.
REQ-003 Parameter SYNC_PERIOD, default 127: sample frames between sync frames; SHALL be >= 2.
REQ-004 Parameter SYNC_WORD, default 24'hAAFF00: sync frame payload, DATA_SIZE bits.
REQ-005 clk  input  1  single system clock; all logic SHALL be on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 ch0_valid / ch1_valid  input  1 each  single-cycle sample strobe, already synchronised to clk.
REQ-008 ch0_data / ch1_data  input  DATA_SIZE each  sample, sampled when the matching valid is high.
REQ-009 fifo_full  input  1  byte-FIFO full flag.
REQ-010 fifo_wr_en  output  1  byte write strobe.
REQ-011 fifo_wr_data  output  8  byte to write.
REQ-012 ch0_ready / ch1_ready  output  1 each  channel slot empty.
REQ-013 drop_count  output  8  saturating count of dropped samples, both channels summed.
REQ-014 busy  output  1  frame in progress.

Function
REQ-015 Each channel SHALL own a one-entry slot: valid with the slot empty loads the slot; valid with the slot occupied drops the sample and increments drop_count, saturating at 8'hFF.
REQ-016 If both channels drop in the same cycle, drop_count SHALL increment by 2, still saturating.
REQ-017 chN_ready SHALL equal "slot N empty".
REQ-018 The FSM SHALL have three states:
- IDLE
- SEND_SYNC
- SEND_SAMPLE
REQ-019 Transitions out of IDLE SHALL be:
- to SEND_SYNC when a slot is occupied and frame_cnt == SYNC_PERIOD;
- otherwise to SEND_SAMPLE when a slot is occupied;
- otherwise stay in IDLE.
REQ-020 Grant SHALL be round-robin: when both slots are occupied, the channel not granted last SHALL win; after reset, ch0 has priority.
REQ-021 On entering SEND_SAMPLE, the granted slot SHALL be copied to a frame register and freed in the same cycle; chN_ready SHALL rise the next cycle.
REQ-022 In SEND_SYNC/SEND_SAMPLE, fifo_wr_en SHALL equal !fifo_full.
- fifo_wr_en is combinational from the state register and fifo_full.
- fifo_wr_data SHALL be frame byte (DATA_SIZE/8-1-byte_idx), i.e. MSB-first.
REQ-023 byte_idx SHALL advance only on a cycle with fifo_wr_en high; fifo_full SHALL stall the frame with no byte lost or repeated.
REQ-024 After byte NUM_BYTES-1 is written, the FSM SHALL behave as follows:
- SEND_SYNC SHALL clear frame_cnt and go directly to SEND_SAMPLE with the pending grant.
- SEND_SAMPLE SHALL increment frame_cnt and go to IDLE.
REQ-025 Write throughput SHALL be one byte per cycle while fifo_full is low; no IDLE cycle SHALL separate a sync frame from its following sample frame.
REQ-026 A sample arriving on the cycle its slot is freed SHALL be accepted, not dropped.
REQ-027 busy SHALL be high in every state other than IDLE.

Reset
REQ-028 While rst_n is low, the block SHALL immediately force:
- FSM to IDLE; slots empty; frame_cnt, byte_idx and drop_count to 0; grant to ch0;
- fifo_wr_en = 0, fifo_wr_data = 0, busy = 0, chN_ready = 1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame; after release no residual byte SHALL be written.

Configuration
REQ-030 With FIFO_ARB_SYNC_EN defined, sync insertion SHALL operate per REQ-019 and REQ-024.
REQ-031 Without FIFO_ARB_SYNC_EN, SEND_SYNC and frame_cnt SHALL be absent, SYNC_PERIOD and SYNC_WORD SHALL be ignored, and only sample frames SHALL be written.

Structure
REQ-032 Package i2s_pkg SHALL hold the FSM state enum fifo_arb_state_t and the default SYNC_WORD constant.
REQ-033 The per-channel slot (holding register, ready, drop pulse) SHALL be a sub-module arb_channel_slot, instantiated twice.

Verification
REQ-034 Single ch0 sample 24'h123456, fifo_full=0 -> bytes 8'h12 then 8'h34 on consecutive cycles; busy for exactly 2 cycles.
REQ-035 ch0 and ch1 valid in the same cycle with 24'hA1A2A3 and 24'hB1B2B3 -> byte order A1, A2, B1, B2; the next simultaneous pair is again ch0 first.
REQ-036 fifo_full held high for 5 cycles after the first byte of 24'hC0C1C2 -> C0, stall, then C1 once; no duplicate byte.
REQ-037 Two ch1 valids 2 cycles apart while ch1 is stalled by fifo_full -> drop_count = 1; 300 drops -> drop_count = 8'hFF.
REQ-038 With FIFO_ARB_SYNC_EN, SYNC_PERIOD=3 and 4 samples -> frames S, S, S, AA FF, S (each S = the sample's bytes); without the macro, 4 sample frames only.
REQ-039 rst_n pulsed low after the first byte of a frame -> fifo_wr_en falls the same cycle; after release nothing is written until a new valid arrives.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared state encoding and default sync payload for the FIFO write arbiter.
// SEND_SYNC exists only when FIFO_ARB_SYNC_EN is defined.
package i2s_pkg;

  localparam logic [23:0] SYNC_WORD_DEFAULT = 24'hAAFF00;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
`ifdef FIFO_ARB_SYNC_EN
    SEND_SYNC   = 2'd1,
`endif
    SEND_SAMPLE = 2'd2
  } fifo_arb_state_t;

endpackage

// File: rtl/arb_channel_slot.sv
// One-entry holding slot for a channel: loads on valid when empty (or being
// freed this cycle), otherwise reports a drop pulse.
module arb_channel_slot #(
  parameter int DATA_SIZE = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic                 free_i,
  output logic                 ready_o,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 drop_o
);

  logic                 full_q, full_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 accept;

  // A free and a load in the same cycle leave the slot occupied with new data.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    accept = valid_i && (!full_q || free_i);
    if (free_i) begin
      full_d = 1'b0;
    end
    if (accept) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign ready_o = !full_q;
  assign data_o  = data_q;
  assign drop_o  = valid_i && full_q && !free_i;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter writing two channels' samples MSB-first into a byte FIFO.
// Define FIFO_ARB_SYNC_EN to insert a SYNC_WORD frame every SYNC_PERIOD frames.
module fifo_write_arbiter
  import i2s_pkg::*;
#(
  parameter int                   DATA_SIZE   = 24,
  parameter int                   NUM_BYTES   = 2,
  parameter int                   SYNC_PERIOD = 127,
  parameter logic [DATA_SIZE-1:0] SYNC_WORD   = DATA_SIZE'(SYNC_WORD_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ch0_valid,
  input  logic [DATA_SIZE-1:0] ch0_data,
  input  logic                 ch1_valid,
  input  logic [DATA_SIZE-1:0] ch1_data,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_wr_data,
  output logic                 ch0_ready,
  output logic                 ch1_ready,
  output logic [7:0]           drop_count,
  output logic                 busy
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  fifo_arb_state_t      state_q, state_d;
  logic [IDX_W-1:0]     byteIdx_q, byteIdx_d;
  logic [DATA_SIZE-1:0] frame_q, frame_d;
  logic                 prio_q, prio_d;
  logic [7:0]           dropCount_q, dropCount_d;

`ifdef FIFO_ARB_SYNC_EN
  localparam int CNT_W = $clog2(SYNC_PERIOD + 1);
  logic [CNT_W-1:0]     frameCnt_q, frameCnt_d;
`else
  logic unused_sync_cfg;
  assign unused_sync_cfg = ^{SYNC_WORD, SYNC_PERIOD};
`endif

  logic [DATA_SIZE-1:0] slotData0, slotData1, frameShift;
  logic                 drop0, drop1, free0, free1;
  logic                 occ0, occ1, grantCh, wrEn, lastByte, startSample;
  logic [8:0]           dropSum;

  arb_channel_slot #(.DATA_SIZE(DATA_SIZE)) u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (ch0_valid),
    .data_i  (ch0_data),
    .free_i  (free0),
    .ready_o (ch0_ready),
    .data_o  (slotData0),
    .drop_o  (drop0)
  );

  arb_channel_slot #(.DATA_SIZE(DATA_SIZE)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (ch1_valid),
    .data_i  (ch1_data),
    .free_i  (free1),
    .ready_o (ch1_ready),
    .data_o  (slotData1),
    .drop_o  (drop1)
  );

  assign occ0     = !ch0_ready;
  assign occ1     = !ch1_ready;
  assign grantCh  = (occ0 && occ1) ? prio_q : occ1;
  assign busy     = (state_q != IDLE);
  assign wrEn     = busy && !fifo_full;
  assign lastByte = wrEn && (byteIdx_q == IDX_W'(NUM_BYTES - 1));

  // A sync frame chains straight into a sample frame so no IDLE gap appears.
  always_comb begin
    state_d     = state_q;
    byteIdx_d   = byteIdx_q;
    frame_d     = frame_q;
    prio_d      = prio_q;
    startSample = 1'b0;
    free0       = 1'b0;
    free1       = 1'b0;
`ifdef FIFO_ARB_SYNC_EN
    frameCnt_d  = frameCnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (occ0 || occ1) begin
`ifdef FIFO_ARB_SYNC_EN
          if (frameCnt_q == CNT_W'(SYNC_PERIOD)) begin
            state_d = SEND_SYNC;
            frame_d = SYNC_WORD;
          end else begin
            startSample = 1'b1;
          end
`else
          startSample = 1'b1;
`endif
        end
      end
`ifdef FIFO_ARB_SYNC_EN
      SEND_SYNC: begin
        if (lastByte) begin
          byteIdx_d   = '0;
          frameCnt_d  = '0;
          startSample = 1'b1;
        end else if (wrEn) begin
          byteIdx_d = byteIdx_q + IDX_W'(1);
        end
      end
`endif
      SEND_SAMPLE: begin
        if (lastByte) begin
          byteIdx_d = '0;
          state_d   = IDLE;
`ifdef FIFO_ARB_SYNC_EN
          frameCnt_d = frameCnt_q + CNT_W'(1);
`endif
        end else if (wrEn) begin
          byteIdx_d = byteIdx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (startSample) begin
      state_d = SEND_SAMPLE;
      frame_d = grantCh ? slotData1 : slotData0;
      free0   = !grantCh;
      free1   = grantCh;
      prio_d  = !grantCh;
    end
  end

  assign dropSum     = {1'b0, dropCount_q} + {8'd0, drop0} + {8'd0, drop1};
  assign dropCount_d = dropSum[8] ? 8'hFF : dropSum[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byteIdx_q   <= '0;
      frame_q     <= '0;
      prio_q      <= 1'b0;
      dropCount_q <= '0;
`ifdef FIFO_ARB_SYNC_EN
      frameCnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      byteIdx_q   <= byteIdx_d;
      frame_q     <= frame_d;
      prio_q      <= prio_d;
      dropCount_q <= dropCount_d;
`ifdef FIFO_ARB_SYNC_EN
      frameCnt_q  <= frameCnt_d;
`endif
    end
  end

  assign frameShift   = frame_q << {byteIdx_q, 3'b000};
  assign fifo_wr_en   = wrEn;
  assign fifo_wr_data = busy ? frameShift[DATA_SIZE-1 -: 8] : 8'h00;
  assign drop_count   = dropCount_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: a byte-queue reference model predicts
// every FIFO write; a monitor checks writes, busy, ready and drop_count each cycle.
module tb_fifo_write_arbiter;

  localparam int          DATA_SIZE   = 24;
  localparam int          NUM_BYTES   = 2;
  localparam int          SYNC_PERIOD = 3;
  localparam logic [23:0] SYNC_WORD   = 24'hAAFF00;
`ifdef FIFO_ARB_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        ch0_valid, ch1_valid, fifo_full;
  logic [23:0] ch0_data, ch1_data;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        ch0_ready, ch1_ready;
  logic [7:0]  drop_count;
  logic        busy;

  int nChecks = 0;
  int nFails  = 0;

  fifo_write_arbiter #(
    .DATA_SIZE   (DATA_SIZE),
    .NUM_BYTES   (NUM_BYTES),
    .SYNC_PERIOD (SYNC_PERIOD),
    .SYNC_WORD   (SYNC_WORD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch0_valid    (ch0_valid),
    .ch0_data     (ch0_data),
    .ch1_valid    (ch1_valid),
    .ch1_data     (ch1_data),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .ch0_ready    (ch0_ready),
    .ch1_ready    (ch1_ready),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: pending samples per channel and the bytes still owed by the
  // frame in flight; one step per cycle, evaluated mid-cycle on stable inputs.
  logic [7:0]  expQ[$];
  logic [7:0]  mCur[$];
  bit          mCurSync  = 1'b0;
  bit          mSlotV[2] = '{1'b0, 1'b0};
  logic [23:0] mSlotD[2] = '{24'h0, 24'h0};
  int          mSinceSync = 0;
  int          mPrio = 0;
  int          mDrops = 0;
  bit          expBusy = 1'b0, expReady0 = 1'b1, expReady1 = 1'b1, expWr = 1'b0;
  logic [7:0]  expDrop = 8'h00;

  function automatic void loadFrame(input logic [23:0] word);
    mCur.delete();
    for (int i = 0; i < NUM_BYTES; i++) mCur.push_back(word[(DATA_SIZE-1-8*i) -: 8]);
  endfunction

  always @(negedge clk) begin : refModel
    bit          start;
    int          ch;
    bit          vin[2];
    logic [23:0] din[2];
    if (!rst_n) begin
      mCur.delete();
      mCurSync   = 1'b0;
      mSlotV     = '{1'b0, 1'b0};
      mSinceSync = 0;
      mPrio      = 0;
      mDrops     = 0;
      expBusy    = 1'b0;
      expReady0  = 1'b1;
      expReady1  = 1'b1;
      expDrop    = 8'h00;
      expWr      = 1'b0;
    end else begin
      expBusy   = (mCur.size() != 0);
      expReady0 = !mSlotV[0];
      expReady1 = !mSlotV[1];
      expDrop   = 8'(mDrops);
      expWr     = 1'b0;
      start     = 1'b0;
      if (mCur.size() == 0) begin
        if (mSlotV[0] || mSlotV[1]) begin
          if (SYNC_ON && mSinceSync == SYNC_PERIOD) begin
            loadFrame(SYNC_WORD);
            mCurSync = 1'b1;
          end else begin
            start = 1'b1;
          end
        end
      end else if (!fifo_full) begin
        expWr = 1'b1;
        expQ.push_back(mCur.pop_front());
        if (mCur.size() == 0) begin
          if (mCurSync) begin
            mSinceSync = 0;
            start = 1'b1;
          end else begin
            mSinceSync++;
          end
        end
      end
      if (start) begin
        ch = (mSlotV[0] && mSlotV[1]) ? mPrio : (mSlotV[1] ? 1 : 0);
        loadFrame(mSlotD[ch]);
        mCurSync   = 1'b0;
        mSlotV[ch] = 1'b0;
        mPrio      = 1 - ch;
      end
      vin[0] = ch0_valid; din[0] = ch0_data;
      vin[1] = ch1_valid; din[1] = ch1_data;
      for (int c = 0; c < 2; c++) begin
        if (vin[c]) begin
          if (!mSlotV[c]) begin
            mSlotV[c] = 1'b1;
            mSlotD[c] = din[c];
          end else begin
            mDrops = (mDrops < 255) ? mDrops + 1 : 255;
          end
        end
      end
    end
  end

  initial begin : monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("ch0_ready", 32'(ch0_ready), 32'(expReady0));
      checkOutput("ch1_ready", 32'(ch1_ready), 32'(expReady1));
      checkOutput("drop_count", 32'(drop_count), 32'(expDrop));
      checkOutput("wr_en", 32'(fifo_wr_en), 32'(expWr));
      if (fifo_wr_en && expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("wr_data", 32'(fifo_wr_data), 32'(e));
      end
    end
  end

  task automatic applyStimulus(input bit v0, input logic [23:0] d0, input bit v1, input logic [23:0] d1);
    ch0_valid = v0;
    ch0_data  = d0;
    ch1_valid = v1;
    ch1_data  = d1;
    @(posedge clk);
    #1;
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitWrite();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = fifo_wr_en;
    end
    if (!seen) checkOutput("wait_write_timeout", 32'(seen), 32'd1);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    rst_n     = 1'b0;
    ch0_valid = 1'b0;
    ch1_valid = 1'b0;
    ch0_data  = '0;
    ch1_data  = '0;
    fifo_full = 1'b0;
    #2;
    checkOutput("reset_wr_en", 32'(fifo_wr_en), 32'd0);
    checkOutput("reset_wr_data", 32'(fifo_wr_data), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ch0_ready", 32'(ch0_ready), 32'd1);
    checkOutput("reset_ch1_ready", 32'(ch1_ready), 32'd1);
    checkOutput("reset_drop_count", 32'(drop_count), 32'd0);
    idle(3);
    rst_n = 1'b1;

    $display("[TB] single sample");
    applyStimulus(1'b1, 24'h123456, 1'b0, 24'h0);
    idle(6);

    $display("[TB] simultaneous pairs");
    applyStimulus(1'b1, 24'hA1A2A3, 1'b1, 24'hB1B2B3);
    idle(10);
    applyStimulus(1'b1, 24'h010203, 1'b1, 24'h040506);
    idle(10);

    $display("[TB] stall after first byte");
    applyStimulus(1'b1, 24'hC0C1C2, 1'b0, 24'h0);
    waitWrite();
    @(posedge clk);
    #1;
    fifo_full = 1'b1;
    idle(5);
    fifo_full = 1'b0;
    idle(6);

    $display("[TB] drops while stalled");
    fifo_full = 1'b1;
    applyStimulus(1'b0, 24'h0, 1'b1, 24'h111111);
    idle(3);
    applyStimulus(1'b0, 24'h0, 1'b1, 24'h222222);
    idle(1);
    applyStimulus(1'b0, 24'h0, 1'b1, 24'h333333);
    idle(1);
    checkOutput("drop_one", 32'(drop_count), 32'd1);
    repeat (150) applyStimulus(1'b1, 24'($urandom), 1'b1, 24'($urandom));
    idle(1);
    checkOutput("drop_saturated", 32'(drop_count), 32'hFF);
    fifo_full = 1'b0;
    idle(20);

    $display("[TB] sync insertion");
    pulseReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 24'h5A0000 + 24'(i * 24'h010100), 1'b0, 24'h0);
      idle(8);
    end

    $display("[TB] reset mid-frame");
    applyStimulus(1'b0, 24'h0, 1'b1, 24'hDEAD77);
    waitWrite();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_wr_en", 32'(fifo_wr_en), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(10);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, 3) == 0, 24'($urandom), $urandom_range(0, 3) == 0, 24'($urandom));
    end

    fifo_full = 1'b0;
    for (int i = 0; i < 100 && (mCur.size() != 0 || mSlotV[0] || mSlotV[1] || expQ.size() != 0); i++) idle(1);
    idle(2);
    checkOutput("drain_scoreboard_empty", 32'(expQ.size()), 32'd0);
    checkOutput("drain_model_idle", 32'(mCur.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
